// File: rtl/int_req_gen_pkg.sv
// Shared interrupt-line ids, line count and handler entry addresses for the request generator and CPU side.
// Constants only: no latency, no backpressure.
package int_req_gen_pkg;

  typedef enum logic [1:0] {
    IR_NONE = 2'd0,
    IR1     = 2'd1,
    IR2     = 2'd2,
    IR3     = 2'd3
  } ir_id_t;

  localparam int NUM_LINES = 3;

  localparam logic [31:0] HANDLER_ADDR [NUM_LINES] = '{
    32'h0000_3024,
    32'h0000_30C8,
    32'h0000_316C
  };

  // Line index 0..2 maps to ack_id 1..3.
  function automatic ir_id_t line_id(input int idx);
    return ir_id_t'(2'(idx + 1));
  endfunction

endpackage

// File: rtl/int_debounce.sv
// One request line: 2-flop synchronizer, plus a stable-count debounce when INT_REQ_DEBOUNCE_EN is defined.
// Latency: 2 edges (sync only) or DEB_CYCLES+2 edges (debounced); no backpressure.
module int_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic clr_n,
  input  logic btn,
  output logic lvl
);

  logic sync_q1;
  logic sync_q2;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
    end
  end

`ifdef INT_REQ_DEBOUNCE_EN
  logic [7:0] deb_cnt;
  logic       deb_lvl;

  // The count hits DEB_CYCLES on the same edge the level flips, so the counter never holds that value.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      deb_cnt <= 8'd0;
      deb_lvl <= 1'b0;
    end else if (sync_q2 == deb_lvl) begin
      deb_cnt <= 8'd0;
    end else if (deb_cnt == 8'(DEB_CYCLES - 1)) begin
      deb_cnt <= 8'd0;
      deb_lvl <= ~deb_lvl;
    end else begin
      deb_cnt <= deb_cnt + 8'd1;
    end
  end

  assign lvl = deb_lvl;
`else
  assign lvl = sync_q2;
`endif

endmodule

// File: rtl/int_req_gen.sv
// Turns three raw button sources into level interrupt requests with lost flags and serviced counters (debounce via INT_REQ_DEBOUNCE_EN).
// Latency: ir rises 3 edges (DEB_CYCLES+3 debounced) after btn; cleared 1 edge after a matching ack; no backpressure.
module int_req_gen
  import int_req_gen_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [2:0]       btn,
  input  logic             ack,
  input  logic [1:0]       ack_id,
  input  logic             lost_clr,
  output logic [2:0]       ir,
  output logic [2:0]       lost,
  output logic [CNT_W-1:0] svc_cnt0,
  output logic [CNT_W-1:0] svc_cnt1,
  output logic [CNT_W-1:0] svc_cnt2
);

  logic [NUM_LINES-1:0] lvl;
  logic [NUM_LINES-1:0] lvl_q;
  logic [NUM_LINES-1:0] evt;
  logic [NUM_LINES-1:0] ack_hit;
  logic [NUM_LINES-1:0] lost_set;
  logic [CNT_W-1:0]     cnt [NUM_LINES];

  for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
    int_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk  (clk),
      .clr_n(clr_n),
      .btn  (btn[g]),
      .lvl  (lvl[g])
    );
  end

  // An ack only counts against a line that is actually pending.
  always_comb begin
    evt      = '0;
    ack_hit  = '0;
    lost_set = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      evt[i]      = lvl[i] & ~lvl_q[i];
      ack_hit[i]  = ack && (ack_id == line_id(i)) && ir[i];
      lost_set[i] = evt[i] & ir[i] & ~ack_hit[i];
    end
  end

  // lvl_q resets to 0 so a source held high across reset still produces one edge.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      lvl_q <= '0;
      ir    <= '0;
      lost  <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      lvl_q <= lvl;
      ir    <= evt | (ir & ~ack_hit);
      lost  <= (lost_clr ? '0 : lost) | lost_set;
      for (int i = 0; i < NUM_LINES; i++) begin
        if (ack_hit[i]) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign svc_cnt0 = cnt[0];
  assign svc_cnt1 = cnt[1];
  assign svc_cnt2 = cnt[2];

endmodule

// File: doc/int_req_gen.md
INT_REQ_GEN -- requirements
Module: int_req_gen

Interface
REQ-001 Parameter: DEB_CYCLES, 16, consecutive stable cycles required before a debounced button level changes; legal range 2..255.
REQ-002 Parameter: CNT_W, 8, width of each per-line serviced-interrupt counter.
REQ-003 Port: clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 Port: clr_n  in  1  reset, synchronous, active-low.
REQ-005 Port: btn  in  3  asynchronous raw request sources; btn[0] feeds IR1, btn[1] feeds IR2, btn[2] feeds IR3.
REQ-006 Port: ack  in  1  one-cycle pulse from the CPU interrupt logic when an eret completes a handler.
REQ-007 Port: ack_id  in  2  line being completed, valid with ack: 1 = IR1, 2 = IR2, 3 = IR3, 0 = none.
REQ-008 Port: lost_clr  in  1  one-cycle pulse that clears all lost flags.
REQ-009 Port: ir  out  3  level interrupt requests to the CPU arbiter; ir[0] = IR1, ir[1] = IR2, ir[2] = IR3.
REQ-010 Port: lost  out  3  sticky per-line flag: a request arrived while the line was already pending.
REQ-011 Port: svc_cnt0/svc_cnt1/svc_cnt2  out  CNT_W each  count of acknowledged requests per line.

Function
REQ-012 Each btn bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Per line, a rising edge of the (debounced, if enabled) synchronized level SHALL be a request event; falling edges produce no event.
REQ-014 A request event SHALL set ir[i] on the next clock edge; ir[i] SHALL stay high until an ack with ack_id = i+1 is sampled.
REQ-015 Ack with matching ack_id on a pending line SHALL clear ir[i] on the next edge and increment svc_cnt[i] by 1, modulo 2^CNT_W (wraps from all-ones to 0, no saturation).
REQ-016 Ack with ack_id = 0, or naming a non-pending line, SHALL be ignored: no ir, counter or lost change.
REQ-017 A request event on a line already pending, with no same-cycle matching ack, SHALL leave ir[i] high and set lost[i].
REQ-018 Same-cycle matching ack and request event on one line: counter SHALL increment, ir[i] SHALL remain high (new request accepted), lost[i] SHALL NOT set.
REQ-019 Events on different lines SHALL be independent; any combination may occur in one cycle with no priority among lines (priority belongs to the CPU arbiter).
REQ-020 lost_clr SHALL clear all lost bits on the next edge; a same-cycle lost-setting event wins (bit ends set).
REQ-021 Without debounce, ir[i] SHALL rise on the 3rd rising edge after btn[i] is first sampled high (2 sync + 1 pending).
REQ-022 Debounce: a per-line counter SHALL count consecutive cycles where the synchronized level differs from the debounced level, reset to 0 on any agreeing cycle; on reaching DEB_CYCLES the debounced level SHALL flip and the counter clear; ir[i] thus rises DEB_CYCLES+3 edges after a clean btn rise.

Reset
REQ-023 While clr_n = 0 at an edge: ir = 0, lost = 0, all svc_cnt = 0, synchronizer flops = 0, debounced levels = 0, debounce counters = 0.
REQ-024 Reset mid-operation SHALL discard pending requests and in-progress debounce without generating an event; a btn held high through reset release SHALL produce exactly one event once it propagates (edge seen against reset level 0).

Configuration
REQ-025 Macro INT_REQ_DEBOUNCE_EN: defined -> debounce stage of REQ-022 present; undefined -> debounce logic and DEB_CYCLES have no effect, synchronized level used directly (REQ-021).

Structure
REQ-026 Shared package SHALL hold: IR line ids (IR1 = 1, IR2 = 2, IR3 = 3, NONE = 0), line count constant 3, and the handler entry addresses 0x00003024, 0x000030C8, 0x0000316C for use by the CPU side.
REQ-027 One sub-module, int_debounce (single line: synchronizer plus optional debounce, outputs debounced level), SHALL be instantiated three times.

Verification
REQ-028 Debounce off: btn[0] 0->1 held -> ir[0] = 1 at edge 3; ack with ack_id = 1 -> ir[0] = 0 next edge, svc_cnt0 = 1.
REQ-029 Debounce on, DEB_CYCLES = 4: btn[1] glitches high 3 cycles -> no ir[1]; held high 10 cycles -> ir[1] = 1 at edge 7.
REQ-030 IR3 pending, second btn[2] rise -> lost = 3'b100, ir[2] stays 1; lost_clr -> lost = 0.
REQ-031 IR2 pending, ack_id = 2 and new IR2 event same cycle -> svc_cnt1 +1, ir[1] stays 1, lost[1] = 0; ack_id = 3 with IR3 idle -> no change.
REQ-032 CNT_W = 8: 256 ack'd IR1 requests -> svc_cnt0 wraps to 0; clr_n low mid-sequence with ir = 3'b111 -> all outputs 0 next edge.
